// File: rtl/as_pkg.sv
// Shared definitions for the writeback arbiter slice: default data width,
// register-address width and the requester encoding used as grant indices.
package as_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } requester_e;

endpackage

// File: rtl/as_rr_arbiter2.sv
// Two-way round-robin arbiter. A lone request is granted directly; on a tie
// the requester that was not granted most recently wins. The pointer only
// moves when the caller reports that the grant was actually accepted.
module as_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  import as_pkg::*;

  requester_e r_last;

  // Grant selection: pass a single request through, break ties against the last winner
  always_comb begin
    gnt = 2'b00;
    if (req[REQ_ALU] && req[REQ_LSU]) begin
      if (r_last == REQ_ALU) gnt[REQ_LSU] = 1'b1;
      else                   gnt[REQ_ALU] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  // Remember who won the last accepted grant; reset treats the ALU as last winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= REQ_ALU;
    end else if (accept) begin
      r_last <= gnt[REQ_LSU] ? REQ_LSU : REQ_ALU;
    end
  end

endmodule

// File: rtl/as_wb_arbiter.sv
// Writeback arbiter: merges ALU and load-unit writebacks onto the single
// register-file write port (one cycle registered latency) and keeps a
// pending-producer mask used for hazard queries.
module as_wb_arbiter #(
  parameter int XLEN = as_pkg::XLEN,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  input  logic [AW-1:0]   raddr01,
  input  logic [AW-1:0]   raddr02,
  output logic            busy01,
  output logic            busy02,
  output logic            we,
  output logic [AW-1:0]   waddr01,
  output logic [XLEN-1:0] wdata01
);
  import as_pkg::*;

  logic [1:0]      w_req;
  logic [1:0]      w_gnt;
  logic            w_accept;
  logic [AW-1:0]   w_rd;
  logic [XLEN-1:0] w_data;
  logic [NREG-1:0] w_pendNext;

  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic [NREG-1:0] r_pending;

  // Requests are masked while in reset so ready stays low without a clock edge
  assign w_req    = {lsu_valid, alu_valid} & {2{rst_n}};
  assign w_accept = |w_gnt;

  as_rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (w_req),
    .accept (w_accept),
    .gnt    (w_gnt)
  );

  assign alu_ready = w_gnt[REQ_ALU];
  assign lsu_ready = w_gnt[REQ_LSU];

  // Pick the payload of whichever requester holds the grant
  always_comb begin
    w_rd   = alu_rd;
    w_data = alu_data;
    if (w_gnt[REQ_LSU]) begin
      w_rd   = lsu_rd;
      w_data = lsu_data;
    end
  end

  // Register the accepted writeback; rd=0 is consumed but never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_accept && (w_rd != '0);
      if (w_accept) begin
        r_waddr <= w_rd;
        r_wdata <= w_data;
      end
    end
  end

  assign we      = r_we;
  assign waddr01 = r_waddr;
  assign wdata01 = r_wdata;

  // Next pending mask: clear on issued write, set on issue (set wins), flush wipes all
  always_comb begin
    w_pendNext = r_pending;
    if (r_we) w_pendNext[r_waddr] = 1'b0;
    if (issue_valid && (issue_rd != '0)) w_pendNext[issue_rd] = 1'b1;
    if (flush) w_pendNext = '0;
  end

  // Pending-producer mask storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pendNext;
  end

  assign busy01 = (raddr01 != '0) && r_pending[raddr01];
  assign busy02 = (raddr02 != '0) && r_pending[raddr02];

endmodule

// File: tb/tb_as_wb_arbiter.sv
// Self-checking bench for as_wb_arbiter: a behavioural model checked every
// cycle on the falling edge, plus directed scenarios with literal expectations.
module tb_as_wb_arbiter;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  logic            clk;
  logic            rst_n;
  logic            alu_valid, lsu_valid;
  logic            alu_ready, lsu_ready;
  logic [4:0]      alu_rd, lsu_rd;
  logic [XLEN-1:0] alu_data, lsu_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            flush;
  logic [4:0]      raddr01, raddr02;
  logic            busy01, busy02;
  logic            we;
  logic [4:0]      waddr01;
  logic [XLEN-1:0] wdata01;

  int checks = 0;
  int errors = 0;

  as_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .raddr01(raddr01), .raddr02(raddr02), .busy01(busy01), .busy02(busy02),
    .we(we), .waddr01(waddr01), .wdata01(wdata01)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: who won last, the expected write port, the pending set
  bit              mLastWasLsu;
  bit              mWe;
  logic [4:0]      mAddr;
  logic [XLEN-1:0] mData;
  bit              mPend [NREG];

  function automatic bit modelGrantLsu();
    if (!rst_n || !lsu_valid) return 1'b0;
    if (!alu_valid) return 1'b1;
    return !mLastWasLsu;
  endfunction

  function automatic bit modelGrantAlu();
    if (!rst_n || !alu_valid) return 1'b0;
    return !modelGrantLsu();
  endfunction

  function automatic bit modelBusy(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 1'b0;
    return mPend[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mLastWasLsu = 1'b0;
      mWe = 1'b0;
      mAddr = '0;
      mData = '0;
      foreach (mPend[i]) mPend[i] = 1'b0;
    end else begin
      bit gl, ga;
      gl = modelGrantLsu();
      ga = modelGrantAlu();
      if (mWe) mPend[mAddr] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) mPend[issue_rd] = 1'b1;
      if (flush) foreach (mPend[i]) mPend[i] = 1'b0;
      mWe = 1'b0;
      if (gl) begin
        mLastWasLsu = 1'b1;
        mWe = (lsu_rd != 5'd0);
        mAddr = lsu_rd;
        mData = lsu_data;
      end else if (ga) begin
        mLastWasLsu = 1'b0;
        mWe = (alu_rd != 5'd0);
        mAddr = alu_rd;
        mData = alu_data;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    checkOutput("model alu_ready", alu_ready, modelGrantAlu());
    checkOutput("model lsu_ready", lsu_ready, modelGrantLsu());
    checkOutput("model we", we, mWe);
    if (mWe) begin
      checkOutput("model waddr01", waddr01, mAddr);
      checkOutput("model wdata01", wdata01, mData);
    end
    checkOutput("model busy01", busy01, modelBusy(raddr01));
    checkOutput("model busy02", busy02, modelBusy(raddr02));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                               input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, '0, 0, 0, '0);
    issue_valid = 0; issue_rd = 0; flush = 0; raddr01 = 0; raddr02 = 0;

    // Reset values hold before any clock edge
    #3;
    alu_valid = 1;
    #1;
    checkOutput("reset we", we, 0);
    checkOutput("reset waddr01", waddr01, 0);
    checkOutput("reset wdata01", wdata01, 0);
    checkOutput("reset alu_ready", alu_ready, 0);
    checkOutput("reset lsu_ready", lsu_ready, 0);
    alu_valid = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Single ALU write
    applyStimulus(1, 5'd1, 64'hdeadbeefdeadbeef, 0, 0, '0);
    #1 checkOutput("alu alone ready", alu_ready, 1);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0);
    checkOutput("alu write we", we, 1);
    checkOutput("alu write waddr", waddr01, 5'd1);
    checkOutput("alu write wdata", wdata01, 64'hdeadbeefdeadbeef);

    // Persistent tie: LSU, ALU, LSU, ALU
    applyStimulus(1, 5'd2, 64'h2222, 1, 5'd3, 64'h3333);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("tie lsu_ready", lsu_ready, (k % 2 == 0));
      checkOutput("tie alu_ready", alu_ready, (k % 2 == 1));
      tick();
      checkOutput("tie we", we, 1);
      checkOutput("tie waddr", waddr01, (k % 2 == 0) ? 5'd3 : 5'd2);
    end
    applyStimulus(0, 0, '0, 0, 0, '0);

    // rd=0 accepted but not written
    applyStimulus(0, 0, '0, 1, 5'd0, 64'hcafebeefbeefcafe);
    #1 checkOutput("rd0 lsu_ready", lsu_ready, 1);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0);
    checkOutput("rd0 we", we, 0);

    // Lone LSU still granted although it won last
    applyStimulus(0, 0, '0, 1, 5'd11, 64'hb0b);
    #1 checkOutput("lone lsu ready", lsu_ready, 1);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0);
    checkOutput("lone lsu waddr", waddr01, 5'd11);
    tick();
    checkOutput("idle we", we, 0);

    // Scoreboard set / clear / set-wins
    raddr01 = 5'd5;
    issue_valid = 1; issue_rd = 5'd5;
    tick();
    issue_valid = 0;
    checkOutput("busy after issue", busy01, 1);
    applyStimulus(1, 5'd5, 64'h55, 0, 0, '0);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0);
    checkOutput("busy while write issues", busy01, 1);
    tick();
    checkOutput("busy cleared", busy01, 0);
    applyStimulus(1, 5'd5, 64'h56, 0, 0, '0);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0);
    issue_valid = 1; issue_rd = 5'd5;
    tick();
    issue_valid = 0;
    checkOutput("set wins over clear", busy01, 1);

    // Flush with simultaneous issue
    for (int r = 4; r <= 7; r++) begin
      if (r != 5) begin
        issue_valid = 1; issue_rd = 5'(r);
        tick();
      end
    end
    issue_valid = 0;
    raddr01 = 5'd4; raddr02 = 5'd6;
    #1;
    checkOutput("busy r4", busy01, 1);
    checkOutput("busy r6", busy02, 1);
    raddr02 = 5'd7;
    #1 checkOutput("busy r7", busy02, 1);
    flush = 1; issue_valid = 1; issue_rd = 5'd8;
    tick();
    flush = 0; issue_valid = 0;
    checkOutput("flush r4", busy01, 0);
    checkOutput("flush r7", busy02, 0);
    raddr01 = 5'd8; raddr02 = 5'd6;
    #1;
    checkOutput("flush r8", busy01, 0);
    checkOutput("flush r6", busy02, 0);
    raddr02 = 5'd5;
    #1 checkOutput("flush r5", busy02, 0);

    // Reset mid-operation
    raddr01 = 5'd10;
    issue_valid = 1; issue_rd = 5'd10;
    tick();
    issue_valid = 0;
    applyStimulus(1, 5'd9, 64'h99, 0, 0, '0);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0);
    checkOutput("pre-reset we", we, 1);
    checkOutput("pre-reset busy r10", busy01, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset we", we, 0);
    checkOutput("async reset waddr", waddr01, 0);
    checkOutput("async reset wdata", wdata01, 0);
    checkOutput("async reset busy", busy01, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    checkOutput("post-reset we", we, 0);
    checkOutput("post-reset busy", busy01, 0);
    applyStimulus(1, 5'd12, 64'hc, 1, 5'd13, 64'hd);
    #1;
    checkOutput("post-reset tie lsu", lsu_ready, 1);
    checkOutput("post-reset tie alu", alu_ready, 0);
    tick();
    applyStimulus(0, 0, '0, 0, 0, '0);
    checkOutput("post-reset tie waddr", waddr01, 5'd13);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/as_wb_arbiter.md
AS_WB_ARBITER -- requirements
Module: as_wb_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning the data width of the register file.
REQ-002 The block SHALL have parameter NREG, default 32, meaning the number of architectural registers; the address width is log2(NREG).
REQ-003 Port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port alu_valid / alu_ready / alu_rd / alu_data  in / out / in[5] / in[XLEN]  ALU writeback request with valid/ready handshake.
REQ-006 Port lsu_valid / lsu_ready / lsu_rd / lsu_data  in / out / in[5] / in[XLEN]  load-unit writeback request with valid/ready handshake.
REQ-007 Port issue_valid / issue_rd  in / in[5]  marks a register as having a pending producer.
REQ-008 Port flush  input  1  clears all pending marks.
REQ-009 Port raddr01 / raddr02  in[5] / in[5]  hazard query addresses.
REQ-010 Port busy01 / busy02  out / out  the queried register has a pending write.
REQ-011 Port we / waddr01 / wdata01  out / out[5] / out[XLEN]  the single register-file write port.
REQ-012 Clock and reset SHALL be one clock, with asynchronous active-low reset rst_n, named clk and rst_n.

Function
REQ-013 The block SHALL accept at most one request per cycle; a request is accepted when valid && ready in the same cycle.
REQ-014 ready SHALL be combinational from the valid inputs and the arbitration pointer; ready SHALL never be high for both requesters in one cycle.
REQ-015 With exactly one requester valid, that requester SHALL be granted.
REQ-016 With both requesters valid, the requester not granted most recently SHALL be granted (round-robin); after reset, the ALU is treated as most recently granted, so the LSU wins the first tie.
REQ-017 The pointer SHALL update only on an accepted request.
REQ-018 Write latency: the accepted rd/data SHALL appear on waddr01/wdata01, with we=1, on the cycle after acceptance (registered outputs); with no accept, we=0 the next cycle.
REQ-019 A request with rd=0 SHALL be accepted and update the pointer but SHALL produce we=0.
REQ-020 The scoreboard SHALL be an NREG-bit pending mask; issue_valid with issue_rd!=0 SHALL set bit issue_rd; an issued write (registered we=1) SHALL clear bit waddr01.
REQ-021 When a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-022 flush SHALL clear the whole mask and SHALL suppress a simultaneous issue set; writebacks SHALL continue unaffected.
REQ-023 busy01 and busy02 SHALL be combinational reads of the mask (pending[raddr]); address 0 SHALL always read 0.
REQ-024 A valid not yet granted SHALL be held by the requester with stable rd/data until accepted (the requester obeys the protocol; the block does not buffer).

Reset
REQ-025 While rst_n=0, we=0, waddr01=0, wdata01=0, the pending mask is 0 and the pointer is ALU-last, SHALL hold immediately, without waiting for a clock edge.
REQ-026 While rst_n=0, alu_ready=lsu_ready=0 and busy01=busy02=0.
REQ-027 Reset asserted mid-operation SHALL drop any registered write, so no we pulse follows reset deassertion.

Structure
REQ-028 XLEN, the register-address width and a requester enum (REQ_ALU, REQ_LSU) SHALL live in shared package as_pkg.
REQ-029 Two-way round-robin grant logic SHALL be a sub-module named as_rr_arbiter2 (req[1:0] -> gnt[1:0], pointer internal, advance on accept).
REQ-030 The scoreboard and output register SHALL stay in as_wb_arbiter; the target is 120-400 lines of RTL.

Verification
REQ-031 After reset, alu_valid=1, rd=1, data=64'hdeadbeefdeadbeef: alu_ready=1 that cycle; next cycle we=1, waddr01=1, wdata01=64'hdeadbeefdeadbeef.
REQ-032 Both valid for 4 cycles (ALU rd=2, LSU rd=3) with the requester re-presenting after each accept: grant order LSU, ALU, LSU, ALU; we=1 every cycle after the first.
REQ-033 LSU valid with rd=0, data=64'hcafebeefbeefcafe: lsu_ready=1; next cycle we=0.
REQ-034 issue_valid rd=5, then raddr01=5: busy01=1 until the cycle after an rd=5 write issues, then 0; a same-cycle issue rd=5 plus write rd=5 leaves busy01=1.
REQ-035 Set bits 4, 6 and 7, then pulse flush together with issue rd=8: the next cycle all busy queries read 0, including rd=8.
REQ-036 Assert rst_n=0 in the cycle after an accept: we=0 immediately and stays 0 after release, and the mask reads 0.
